// File: rtl/exa_crosb_output_vc_credit_arbiter_if.sv
// exa_crosb_output_vc_credit_arbiter_if: request/grant/credit bundle between upstream VCs, arbiter and link
interface exa_crosb_output_vc_credit_arbiter_if #(
    parameter int prio_num = 2,
    parameter int vc_num   = 2
);
    localparam int N = prio_num * vc_num;
    localparam int W = (N > 1) ? $clog2(N) : 1;
    logic [N-1:0][W-1:0] i_output_vc;
    logic [N-1:0]        i_req;
    logic [N-1:0]        i_req_tail;
    logic [N-1:0]        o_grant;
    logic                o_grant_valid;
    logic [W-1:0]        o_grant_ovc;
    logic                i_credit_valid;
    logic [W-1:0]        i_credit_vc;
    logic [N-1:0]        o_ovc_busy;
    logic [N-1:0]        o_credit_zero;
    logic                o_credit_err;
    modport master (
        output i_output_vc, i_req, i_req_tail, i_credit_valid, i_credit_vc,
        input  o_grant, o_grant_valid, o_grant_ovc, o_ovc_busy, o_credit_zero, o_credit_err
    );
    modport slave (
        input  i_output_vc, i_req, i_req_tail, i_credit_valid, i_credit_vc,
        output o_grant, o_grant_valid, o_grant_ovc, o_ovc_busy, o_credit_zero, o_credit_err
    );
endinterface

// File: rtl/exa_crosb_output_vc_credit_arbiter.sv
// exa_crosb_output_vc_credit_arbiter: round-robin flit grant per output port with per-VC credits and packet ownership
module exa_crosb_output_vc_credit_arbiter #(
    parameter int prio_num   = 2,
    parameter int vc_num     = 2,
    parameter int credit_max = 8
) (
    input logic clk,
    input logic resetn,
    exa_crosb_output_vc_credit_arbiter_if.slave bus
);
    localparam int N         = prio_num * vc_num;
    localparam int logVcPrio = (N > 1) ? $clog2(N) : 1;
    localparam int logCred   = $clog2(credit_max + 1);
    localparam logic [logCred-1:0] cred_full = logCred'(credit_max);

    typedef enum logic {FREE, OWNED} own_t;

    own_t                 own_q   [N];
    own_t                 own_d   [N];
    logic [logVcPrio-1:0] owner_q [N];
    logic [logVcPrio-1:0] owner_d [N];
    logic [logCred-1:0]   credit_q[N];
    logic [logCred-1:0]   credit_d[N];
    logic [logVcPrio-1:0] rr_q, rr_d;
    logic                 err_q, err_d;
    logic [N-1:0]         elig, dec, inc, full;
    logic                 gnt_vld;
    logic [logVcPrio-1:0] gnt_idx, gnt_ovc;
    logic                 gnt_tail;

    always_comb begin
        elig = '0;
        for (int n = 0; n < N; n++)
            elig[n] = bus.i_req[n] && credit_q[bus.i_output_vc[n]] != '0 &&
                      (own_q[bus.i_output_vc[n]] == FREE || owner_q[bus.i_output_vc[n]] == logVcPrio'(n));
    end

    // First eligible VC at or after the pointer wins; grants are masked while in reset
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_vld && elig[(int'(rr_q) + i) % N]) begin
                gnt_vld = 1'b1;
                gnt_idx = logVcPrio'((int'(rr_q) + i) % N);
            end
        end
        gnt_vld = gnt_vld & resetn;
    end

    assign gnt_ovc  = gnt_vld ? bus.i_output_vc[gnt_idx] : '0;
    assign gnt_tail = bus.i_req_tail[gnt_idx];
    assign dec      = gnt_vld ? (N'(1) << gnt_ovc) : '0;
    assign inc      = bus.i_credit_valid ? (N'(1) << bus.i_credit_vc) : '0;

    assign bus.o_grant       = gnt_vld ? (N'(1) << gnt_idx) : '0;
    assign bus.o_grant_valid = gnt_vld;
    assign bus.o_grant_ovc   = gnt_ovc;
    assign bus.o_credit_err  = err_q;

    always_comb begin
        for (int m = 0; m < N; m++) begin
            full[m]              = credit_q[m] == cred_full;
            bus.o_credit_zero[m] = credit_q[m] == '0;
            bus.o_ovc_busy[m]    = own_q[m] == OWNED;
        end
    end

    always_comb begin
        own_d   = own_q;
        owner_d = owner_q;
        rr_d    = gnt_vld ? ((gnt_idx == logVcPrio'(N - 1)) ? '0 : gnt_idx + 1'b1) : rr_q;
        err_d   = err_q | (|(inc & ~dec & full));
        if (gnt_vld) begin
            own_d[gnt_ovc]   = gnt_tail ? FREE : OWNED;
            owner_d[gnt_ovc] = gnt_idx;
        end
        for (int m = 0; m < N; m++)
            credit_d[m] = (dec[m] && !inc[m]) ? credit_q[m] - 1'b1 :
                          (inc[m] && !dec[m] && !full[m]) ? credit_q[m] + 1'b1 : credit_q[m];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q  <= '0;
            err_q <= 1'b0;
            for (int m = 0; m < N; m++) begin
                own_q[m]    <= FREE;
                owner_q[m]  <= '0;
                credit_q[m] <= cred_full;
            end
        end else begin
            rr_q     <= rr_d;
            err_q    <= err_d;
            own_q    <= own_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
        end
    end
endmodule
